// File: rtl/jpeg_ff_stuffer.sv
// jpeg_ff_stuffer
// Pops 32-bit entropy-coded words from the FF-check FIFO, inserts a 0x00
// after every 0xFF data byte (JPEG byte stuffing) and repacks the stream
// into big-endian 32-bit output words. An end-of-image entry switches to
// FLUSH, which drains the buffer and marks the final, possibly partial,
// word with out_last. A saturating counter tracks inserted stuff bytes.
module jpeg_ff_stuffer #(
  parameter int BUF_BYTES = 12,  // fixed: the count<=4 read rule is sized for it
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [90:0]      fifo_rdata,
  input  logic             fifo_rvalid,
  output logic             read_req,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [2:0]       out_bytes,
  output logic [CNT_W-1:0] stuff_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Registered state
  state_e           state_q, state_d;
  logic [7:0]       buf_q [BUF_BYTES];
  logic [7:0]       buf_d [BUF_BYTES];
  logic [3:0]       count_q, count_d;
  logic             rd_pending_q, rd_pending_d;
  logic [CNT_W-1:0] stuff_q, stuff_d;

  // FIFO entry fields
  logic [31:0] in_word;
  logic [2:0]  in_nb_raw;
  logic [2:0]  in_nb;
  logic        in_eoi;
  logic        unused_rdata;

  // Stuffed form of the incoming entry: up to 8 bytes when every byte is 0xFF
  logic [7:0]  stuffed [8];
  logic [3:0]  stuffed_n;
  logic [2:0]  ff_n;

  // Pop/append bookkeeping
  logic             append;
  logic             pop;
  logic [3:0]       pop_n;
  logic [3:0]       rem;
  logic [3:0]       src;
  logic [3:0]       dst;
  logic [CNT_W:0]   stuff_sum;

  assign in_word      = fifo_rdata[31:0];
  assign in_nb_raw    = fifo_rdata[34:32];
  assign in_eoi       = fifo_rdata[35];
  assign unused_rdata = ^fifo_rdata[90:36];

  // A byte count of 0 means a full word; codes above 4 are treated alike
  assign in_nb = (in_nb_raw == 3'd0 || in_nb_raw > 3'd4) ? 3'd4 : in_nb_raw;

  // Only data we actually asked for is appended, so a read that was in
  // flight across a reset cannot leak stale bytes into the next image.
  assign append = fifo_rvalid && rd_pending_q;

  // Output decode straight from registered state; nothing here depends on
  // out_ready, so data/last/bytes hold while the consumer stalls.
  assign read_req    = (state_q == RUN) && !fifo_empty && !rd_pending_q
                       && (count_q <= 4'd4);
  assign out_valid   = (state_q == RUN) ? (count_q >= 4'd4) : (count_q != 4'd0);
  assign out_last    = (state_q == FLUSH) && (count_q <= 4'd4);
  assign out_bytes   = out_last ? count_q[2:0] : 3'd4;
  assign stuff_count = stuff_q;

  // Present the four oldest bytes, zero-padding anything past count
  always_comb begin
    out_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (4'(k) < count_q) out_data[31-8*k -: 8] = buf_q[k];
    end
  end

  // Expand the incoming entry into its stuffed byte sequence
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned, which would otherwise infer a latch.
    stuffed   = '{default: 8'h00};
    stuffed_n = 4'd0;
    ff_n      = 3'd0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < in_nb) begin
        stuffed[stuffed_n[2:0]] = in_word[31-8*k -: 8];
        stuffed_n               = stuffed_n + 4'd1;
        if (in_word[31-8*k -: 8] == 8'hFF) begin
          stuffed[stuffed_n[2:0]] = 8'h00;
          stuffed_n               = stuffed_n + 4'd1;
          ff_n                    = ff_n + 3'd1;
        end
      end
    end
  end

  // Next-state: pop from the front first, then append behind the remainder
  always_comb begin
    pop   = out_valid && out_ready;
    pop_n = pop ? (out_last ? count_q : 4'd4) : 4'd0;
    rem   = count_q - pop_n;
    src   = 4'd0;
    dst   = 4'd0;

    for (int i = 0; i < BUF_BYTES; i++) begin
      src      = 4'(i) + pop_n;
      dst      = 4'(i) - rem;
      buf_d[i] = (src < 4'(BUF_BYTES)) ? buf_q[src] : 8'h00;
      if (append && (4'(i) >= rem) && (dst < stuffed_n)) begin
        buf_d[i] = stuffed[dst[2:0]];
      end
    end

    count_d      = rem + (append ? stuffed_n : 4'd0);
    rd_pending_d = read_req || (rd_pending_q && !fifo_rvalid);

    // Saturate rather than wrap so a long image cannot fake a small count
    stuff_sum = {1'b0, stuff_q} + (append ? (CNT_W+1)'(ff_n) : '0);
    stuff_d   = stuff_sum[CNT_W] ? '1 : stuff_sum[CNT_W-1:0];

    state_d = state_q;
    case (state_q)
      RUN:   if (append && in_eoi) state_d = FLUSH;
      FLUSH: if (pop && out_last)  state_d = RUN;
    endcase
  end

  // Control state, byte count, read tracking and stuff counter
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= RUN;
      count_q      <= 4'd0;
      rd_pending_q <= 1'b0;
      stuff_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_pending_q <= rd_pending_d;
      stuff_q      <= stuff_d;
    end
  end

  // Byte storage
  // NOTE: the byte array is deliberately not reset; bytes at or beyond
  // count are never observed because out_data masks them to 0x00.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_jpeg_ff_stuffer.sv
// tb_jpeg_ff_stuffer
// Directed and randomized stimulus for jpeg_ff_stuffer. A behavioural FIFO
// feeds the DUT; a byte-queue reference model predicts the stuffed stream
// and a monitor compares every accepted output word against it.
module tb_jpeg_ff_stuffer;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             fifo_empty;
  logic [90:0]      fifo_rdata;
  logic             fifo_rvalid;
  logic             read_req;
  logic [31:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [2:0]       out_bytes;
  logic [CNT_W-1:0] stuff_count;

  jpeg_ff_stuffer #(.BUF_BYTES(12), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rdata  (fifo_rdata),
    .fifo_rvalid (fifo_rvalid),
    .read_req    (read_req),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .out_bytes   (out_bytes),
    .stuff_count (stuff_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters
  int n_vec = 0;
  int n_bad = 0;

  // Behavioural FIFO contents and reference model state
  logic [90:0] fifo_q [$];
  logic [7:0]  exp_bytes [$];
  logic        eoi_pushed = 1'b0;
  int          exp_stuff  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_bytes.delete();
    eoi_pushed = 1'b0;
    exp_stuff  = 0;
  endtask

  // Queue one FIFO entry and record the stuffed bytes it must produce
  task automatic push_entry(input logic [31:0] data, input logic [2:0] nb, input logic eoi);
    int          n;
    logic [7:0]  b;
    logic [63:0] junk;
    n = (nb == 3'd0) ? 4 : int'(nb);
    for (int k = 0; k < n; k++) begin
      b = data[31-8*k -: 8];
      exp_bytes.push_back(b);
      if (b == 8'hFF) begin
        exp_bytes.push_back(8'h00);
        exp_stuff++;
      end
    end
    if (eoi) eoi_pushed = 1'b1;
    junk = {$urandom, $urandom};
    fifo_q.push_back({junk[54:0], eoi, nb, data});
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w[31-8*k -: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
    end
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Run until the model has nothing left to see, optionally jittering out_ready
  task automatic drain(input int budget, input bit rnd_ready);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && exp_bytes.size() == 0) break;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    out_ready = 1'b1;
    check("drain_left", 32'(fifo_q.size() + exp_bytes.size()), 32'd0);
  endtask

  // Behavioural FIFO: grant a read seen before an edge, return data next cycle
  initial begin : fifo_model
    logic        accepted;
    logic [90:0] next_ent;
    accepted    = 1'b0;
    next_ent    = '0;
    fifo_rvalid = 1'b0;
    fifo_rdata  = '0;
    fifo_empty  = 1'b1;
    forever begin
      @(negedge clk);
      fifo_rvalid = accepted;
      if (accepted) fifo_rdata = next_ent;
      fifo_empty = (fifo_q.size() == 0);
      #1;
      accepted = 1'b0;
      if (read_req === 1'b1 && rst === 1'b0 && fifo_q.size() > 0) begin
        next_ent = fifo_q.pop_front();
        accepted = 1'b1;
      end
    end
  end

  // Output monitor: stability under stall, word contents on each handshake
  initial begin : monitor
    logic        held;
    logic [31:0] h_data;
    logic        h_last;
    logic [2:0]  h_bytes;
    int          n_rem;
    logic        e_last;
    int          e_nb;
    logic [31:0] e_word;
    held = 1'b0;
    h_data = '0;
    h_last = 1'b0;
    h_bytes = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b0) begin
        held = 1'b0;
        continue;
      end
      check("count_le_12", 32'(dut.count_q <= 4'd12), 32'd1);
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data",  out_data, h_data);
        check("hold_last",  32'(out_last), 32'(h_last));
        check("hold_bytes", 32'(out_bytes), 32'(h_bytes));
      end
      held = 1'b0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          n_rem  = exp_bytes.size();
          e_last = eoi_pushed && (n_rem <= 4);
          e_nb   = e_last ? n_rem : 4;
          e_word = '0;
          for (int k = 0; k < 4; k++) begin
            if (k < e_nb && exp_bytes.size() > 0) e_word[31-8*k -: 8] = exp_bytes.pop_front();
          end
          check("word_data",  out_data, e_word);
          check("word_last",  32'(out_last), 32'(e_last));
          check("word_bytes", 32'(out_bytes), 32'(e_nb));
          if (e_last) eoi_pushed = 1'b0;
        end else begin
          held    = 1'b1;
          h_data  = out_data;
          h_last  = out_last;
          h_bytes = out_bytes;
        end
      end
    end
  end

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog: run exceeded time limit, vectors=%0d miscompares=%0d", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int got;
    rst       = 1'b1;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    check("rst_read_req",    32'(read_req), 32'd0);
    check("rst_out_valid",   32'(out_valid), 32'd0);
    check("rst_out_last",    32'(out_last), 32'd0);
    check("rst_out_bytes",   32'(out_bytes), 32'd4);
    check("rst_out_data",    out_data, 32'h0);
    check("rst_stuff_count", 32'(stuff_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Plain data, plus read_req -> out_valid latency into an empty buffer
    @(negedge clk);
    #3;
    push_entry(32'h11223344, 3'd4, 1'b0);
    push_entry(32'h55667788, 3'd4, 1'b0);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      #3;
      if (read_req === 1'b1) got = 1;
    end
    check("lat_read_req", 32'(got), 32'd1);
    @(negedge clk);
    #3;
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #3;
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("lat_cycle2_data",  out_data, 32'h11223344);
    drain(200, 1'b0);
    check("plain_stuff", 32'(stuff_count), 32'(exp_stuff));

    // Single FF followed by an eoi entry
    push_entry(32'h12FF3456, 3'd4, 1'b0);
    push_entry(32'hAABBCCDD, 3'd4, 1'b1);
    drain(200, 1'b0);
    check("ff1_stuff", 32'(stuff_count), 32'(exp_stuff));
    #3;
    check("ff1_idle_valid", 32'(out_valid), 32'd0);

    // All-FF worst case from a fresh reset
    do_reset();
    push_entry(32'hFFFFFFFF, 3'd4, 1'b1);
    drain(200, 1'b0);
    check("allff_stuff", 32'(stuff_count), 32'd4);

    // Backpressure: reads must stop once the buffer holds more than 4 bytes
    @(negedge clk);
    out_ready = 1'b0;
    for (int e = 0; e < 5; e++) push_entry(rand_word(), 3'd4, 1'b0);
    repeat (10) @(negedge clk);
    #3;
    check("bp_read_req",  32'(read_req), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_fifo_left", 32'(fifo_q.size() > 0), 32'd1);
    push_entry(rand_word(), 3'($urandom_range(0, 4)), 1'b1);
    drain(500, 1'b0);
    check("bp_stuff", 32'(stuff_count), 32'(exp_stuff));

    // Partial final entries; trailing bytes past nbytes must be ignored
    push_entry(32'hAB000000, 3'd1, 1'b1);
    drain(200, 1'b0);
    push_entry(32'hABFFFFFF, 3'd1, 1'b1);
    drain(200, 1'b0);
    check("partial_stuff", 32'(stuff_count), 32'(exp_stuff));
    @(negedge clk);
    #3;
    push_entry(32'h01020304, 3'd4, 1'b0);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      #3;
      if (read_req === 1'b1) got = 1;
    end
    check("partial_back_to_run", 32'(got), 32'd1);
    drain(200, 1'b0);

    // Reset while in FLUSH holding 6 bytes
    @(negedge clk);
    out_ready = 1'b0;
    push_entry(32'h11223344, 3'd4, 1'b0);
    push_entry(32'h5566FFFF, 3'd2, 1'b1);
    repeat (12) @(negedge clk);
    #3;
    check("mf_count",     32'(dut.count_q), 32'd6);
    check("mf_out_valid", 32'(out_valid), 32'd1);
    check("mf_out_last",  32'(out_last), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #3;
    check("mf_rst_valid",    32'(out_valid), 32'd0);
    check("mf_rst_stuff",    32'(stuff_count), 32'd0);
    check("mf_rst_read_req", 32'(read_req), 32'd0);
    out_ready = 1'b1;

    // Randomized images with jittered out_ready
    for (int img = 0; img < 8; img++) begin
      int n_ent;
      n_ent = $urandom_range(1, 6);
      for (int e = 0; e < n_ent; e++) begin
        push_entry(rand_word(), 3'($urandom_range(0, 4)), (e == n_ent - 1) ? 1'b1 : 1'b0);
      end
      drain(2000, 1'b1);
      check("rand_stuff", 32'(stuff_count), 32'(exp_stuff));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
